// File: rtl/axi_to_mem_r_pkg.sv
// Shared constants, state encoding and R-beat field layout for the AXI-to-memory R path.
package axi_to_mem_r_pkg;

    localparam int unsigned LenWidth  = 8;
    localparam int unsigned RespWidth = 2;

    localparam logic [RespWidth-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RespWidth-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RespWidth-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RespWidth-1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Beat layout, MSB..LSB: id, data, resp, last, user.
    function automatic int unsigned beat_width(input int unsigned id_w,
                                               input int unsigned data_w,
                                               input int unsigned user_w);
        return id_w + data_w + RespWidth + 1 + user_w;
    endfunction

    function automatic int unsigned user_lsb();
        return 0;
    endfunction

    function automatic int unsigned last_bit(input int unsigned user_w);
        return user_w;
    endfunction

    function automatic int unsigned resp_lsb(input int unsigned user_w);
        return user_w + 1;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned user_w);
        return user_w + 1 + RespWidth;
    endfunction

    function automatic int unsigned id_lsb(input int unsigned data_w,
                                           input int unsigned user_w);
        return data_w + user_w + 1 + RespWidth;
    endfunction

endpackage

// File: rtl/axi_to_mem_r_beat_pack.sv
// Combinational packer placing R-beat fields into the flat FIFO word.
module axi_to_mem_r_beat_pack
    import axi_to_mem_r_pkg::*;
#(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned UserWidth = 1,
    localparam int unsigned RBeatWidth = IdWidth + DataWidth + 3 + UserWidth
) (
    input  logic [IdWidth-1:0]    id,
    input  logic [DataWidth-1:0]  data,
    input  logic [RespWidth-1:0]  resp,
    input  logic                  last,
    input  logic [UserWidth-1:0]  user,
    output logic [RBeatWidth-1:0] beat
);

    localparam int unsigned UserLsb = user_lsb();
    localparam int unsigned LastBit = last_bit(UserWidth);
    localparam int unsigned RespLsb = resp_lsb(UserWidth);
    localparam int unsigned DataLsb = data_lsb(UserWidth);
    localparam int unsigned IdLsb   = id_lsb(DataWidth, UserWidth);

    always_comb begin
        beat                           = '0;
        beat[UserLsb +: UserWidth]     = user;
        beat[LastBit]                  = last;
        beat[RespLsb +: RespWidth]     = resp;
        beat[DataLsb +: DataWidth]     = data;
        beat[IdLsb +: IdWidth]         = id;
    end

endmodule

// File: rtl/axi_to_mem_r_beat_gen.sv
// Pairs AR burst metadata with memory read beats and pushes packed R beats into the R FIFO.
// Optional statistics counters are enabled with `define AXI_TO_MEM_R_STATS_EN.
module axi_to_mem_r_beat_gen
    import axi_to_mem_r_pkg::*;
#(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned UserWidth = 1,
    localparam int unsigned RBeatWidth = IdWidth + DataWidth + 3 + UserWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  meta_valid_i,
    output logic                  meta_ready_o,
    input  logic [IdWidth-1:0]    meta_id_i,
    input  logic [LenWidth-1:0]   meta_len_i,
    input  logic [UserWidth-1:0]  meta_user_i,
    input  logic                  mem_rvalid_i,
    output logic                  mem_rready_o,
    input  logic [DataWidth-1:0]  mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  push_o,
    output logic [RBeatWidth-1:0] data_o,
    input  logic                  full_i
`ifdef AXI_TO_MEM_R_STATS_EN
    ,
    output logic [31:0]           stat_beats_o,
    output logic [31:0]           stat_bursts_o
`endif
);

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic [UserWidth-1:0] user_q, user_d;
    logic [LenWidth-1:0]  cnt_q, cnt_d;

    logic                 in_burst;
    logic                 is_last;
    logic                 xfer;
    logic                 meta_fire;
    logic [RespWidth-1:0] resp;

    // State and burst-metadata registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            len_q   <= '0;
            user_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            user_q  <= user_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, handshakes and beat fields; flush overrides every update.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        len_d        = len_q;
        user_d       = user_q;
        cnt_d        = cnt_q;

        in_burst     = (state_q == BURST);
        is_last      = in_burst && (cnt_q == len_q);
        xfer         = in_burst && mem_rvalid_i && !full_i && !flush_i;
        push_o       = in_burst && mem_rvalid_i && !flush_i;
        mem_rready_o = in_burst && !full_i && !flush_i;
        meta_ready_o = !flush_i && (!in_burst || (xfer && is_last));
        meta_fire    = meta_valid_i && meta_ready_o;
        resp         = (in_burst && mem_err_i) ? RESP_SLVERR : RESP_OKAY;

        if (flush_i) begin
            state_d = IDLE;
            id_d    = '0;
            len_d   = '0;
            user_d  = '0;
            cnt_d   = '0;
        end else begin
            if (xfer) begin
                if (is_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = LenWidth'(cnt_q + LenWidth'(1));
                end
            end
            // A new burst loaded in the last-beat cycle follows with no bubble.
            if (meta_fire) begin
                state_d = BURST;
                id_d    = meta_id_i;
                len_d   = meta_len_i;
                user_d  = meta_user_i;
                cnt_d   = '0;
            end
        end
    end

    axi_to_mem_r_beat_pack #(
        .IdWidth   (IdWidth),
        .DataWidth (DataWidth),
        .UserWidth (UserWidth)
    ) u_pack (
        .id   (id_q),
        .data (mem_rdata_i),
        .resp (resp),
        .last (is_last),
        .user (user_q),
        .beat (data_o)
    );

`ifdef AXI_TO_MEM_R_STATS_EN
    logic [31:0] stat_beats_q;
    logic [31:0] stat_bursts_q;

    // Lifetime counters survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_beats_q  <= '0;
            stat_bursts_q <= '0;
        end else begin
            if (xfer) begin
                stat_beats_q <= stat_beats_q + 32'd1;
            end
            if (xfer && is_last) begin
                stat_bursts_q <= stat_bursts_q + 32'd1;
            end
        end
    end

    assign stat_beats_o  = stat_beats_q;
    assign stat_bursts_o = stat_bursts_q;
`endif

endmodule

// File: tb/tb_axi_to_mem_r_beat_gen.sv
// Directed self-checking bench for axi_to_mem_r_beat_gen (default widths 4/64/1).
module tb_axi_to_mem_r_beat_gen;

    localparam int unsigned IdW   = 4;
    localparam int unsigned DataW = 64;
    localparam int unsigned UserW = 1;
    localparam int unsigned BeatW = IdW + DataW + 3 + UserW;

    logic             clk_i;
    logic             rst_ni;
    logic             flush_i;
    logic             meta_valid_i;
    logic             meta_ready_o;
    logic [IdW-1:0]   meta_id_i;
    logic [7:0]       meta_len_i;
    logic [UserW-1:0] meta_user_i;
    logic             mem_rvalid_i;
    logic             mem_rready_o;
    logic [DataW-1:0] mem_rdata_i;
    logic             mem_err_i;
    logic             push_o;
    logic [BeatW-1:0] data_o;
    logic             full_i;
`ifdef AXI_TO_MEM_R_STATS_EN
    logic [31:0]      stat_beats_o;
    logic [31:0]      stat_bursts_o;
`endif

    int checks;
    int failures;

    axi_to_mem_r_beat_gen dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .meta_valid_i (meta_valid_i),
        .meta_ready_o (meta_ready_o),
        .meta_id_i    (meta_id_i),
        .meta_len_i   (meta_len_i),
        .meta_user_i  (meta_user_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rready_o (mem_rready_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i),
        .push_o       (push_o),
        .data_o       (data_o),
        .full_i       (full_i)
`ifdef AXI_TO_MEM_R_STATS_EN
        ,
        .stat_beats_o  (stat_beats_o),
        .stat_bursts_o (stat_bursts_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BeatW-1:0] beat(input logic [IdW-1:0] id, input logic [DataW-1:0] d,
                                              input logic [1:0] r, input logic l,
                                              input logic [UserW-1:0] u);
        return {id, d, r, l, u};
    endfunction

    // Inputs are driven 1ns after the rising edge; outputs are sampled 2ns later.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic load_meta(input logic [IdW-1:0] id, input logic [7:0] len, input logic [UserW-1:0] u);
        meta_valid_i = 1'b1;
        meta_id_i    = id;
        meta_len_i   = len;
        meta_user_i  = u;
        settle();
        check("meta_ready_idle", 128'(meta_ready_o), 128'(1'b1));
        next_cycle();
        meta_valid_i = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        meta_valid_i = 1'b0;
        meta_id_i    = '0;
        meta_len_i   = '0;
        meta_user_i  = '0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 64'h1234;
        mem_err_i    = 1'b0;
        full_i       = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        settle();
        check("rst_meta_ready", 128'(meta_ready_o), 128'(1'b1));
        check("rst_mem_rready", 128'(mem_rready_o), 128'(1'b0));
        check("rst_push", 128'(push_o), 128'(1'b0));
        check("rst_data", 128'(data_o), 128'(beat(4'd0, 64'h1234, 2'b00, 1'b0, 1'b0)));
        rst_ni = 1'b1;
        next_cycle();

        // Memory data with no burst outstanding must stall
        mem_rvalid_i = 1'b1;
        settle();
        check("idle_push", 128'(push_o), 128'(1'b0));
        check("idle_rready", 128'(mem_rready_o), 128'(1'b0));
        next_cycle();
        mem_rvalid_i = 1'b0;

        // Single beat burst
        load_meta(4'd3, 8'd0, 1'b1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEADBEEF;
        settle();
        check("single_push", 128'(push_o), 128'(1'b1));
        check("single_rready", 128'(mem_rready_o), 128'(1'b1));
        check("single_data", 128'(data_o), 128'(beat(4'd3, 64'hDEADBEEF, 2'b00, 1'b1, 1'b1)));
        check("single_meta_ready", 128'(meta_ready_o), 128'(1'b1));
        next_cycle();
        settle();
        check("single_back_idle_push", 128'(push_o), 128'(1'b0));
        check("single_back_idle_ready", 128'(meta_ready_o), 128'(1'b1));
        mem_rvalid_i = 1'b0;

        // Four-beat burst with two full cycles stalling beat 2
        load_meta(4'd5, 8'd3, 1'b0);
        mem_rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rdata_i = 64'(i);
            if (i == 2) begin
                full_i = 1'b1;
                for (int s = 0; s < 2; s++) begin
                    settle();
                    check("full_push", 128'(push_o), 128'(1'b1));
                    check("full_rready", 128'(mem_rready_o), 128'(1'b0));
                    check("full_data", 128'(data_o), 128'(beat(4'd5, 64'd2, 2'b00, 1'b0, 1'b0)));
                    check("full_meta_ready", 128'(meta_ready_o), 128'(1'b0));
                    next_cycle();
                end
                full_i = 1'b0;
            end
            settle();
            check("b4_push", 128'(push_o), 128'(1'b1));
            check("b4_rready", 128'(mem_rready_o), 128'(1'b1));
            check("b4_data", 128'(data_o), 128'(beat(4'd5, 64'(i), 2'b00, i == 3, 1'b0)));
            check("b4_meta_ready", 128'(meta_ready_o), 128'(i == 3));
            next_cycle();
        end
        mem_rvalid_i = 1'b0;

        // Back-to-back bursts with continuous meta and memory valid
        meta_valid_i = 1'b1;
        meta_id_i    = 4'd1;
        meta_len_i   = 8'd1;
        meta_user_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hA0;
        settle();
        check("b2b_idle_push", 128'(push_o), 128'(1'b0));
        next_cycle();
        meta_id_i  = 4'd2;
        meta_len_i = 8'd0;
        settle();
        check("b2b_0", 128'(data_o), 128'(beat(4'd1, 64'hA0, 2'b00, 1'b0, 1'b0)));
        check("b2b_0_push", 128'(push_o), 128'(1'b1));
        check("b2b_0_ready", 128'(meta_ready_o), 128'(1'b0));
        next_cycle();
        mem_rdata_i = 64'hA1;
        settle();
        check("b2b_1", 128'(data_o), 128'(beat(4'd1, 64'hA1, 2'b00, 1'b1, 1'b0)));
        check("b2b_1_push", 128'(push_o), 128'(1'b1));
        check("b2b_1_ready", 128'(meta_ready_o), 128'(1'b1));
        next_cycle();
        meta_valid_i = 1'b0;
        mem_rdata_i  = 64'hA2;
        settle();
        check("b2b_2", 128'(data_o), 128'(beat(4'd2, 64'hA2, 2'b00, 1'b1, 1'b0)));
        check("b2b_2_push", 128'(push_o), 128'(1'b1));
        next_cycle();
        mem_rvalid_i = 1'b0;

        // Error on the last beat of a three-beat burst
        load_meta(4'd7, 8'd2, 1'b1);
        mem_rvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rdata_i = 64'h10 + 64'(i);
            mem_err_i   = (i == 2);
            settle();
            check("err_data", 128'(data_o),
                  128'(beat(4'd7, 64'h10 + 64'(i), (i == 2) ? 2'b10 : 2'b00, i == 2, 1'b1)));
            next_cycle();
        end
        mem_err_i    = 1'b0;
        mem_rvalid_i = 1'b0;

        // Flush at beat 1 of an eight-beat burst
        load_meta(4'd9, 8'd7, 1'b0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h55;
        settle();
        check("flush_b0_push", 128'(push_o), 128'(1'b1));
        next_cycle();
        flush_i     = 1'b1;
        mem_rdata_i = 64'h66;
        settle();
        check("flush_push", 128'(push_o), 128'(1'b0));
        check("flush_rready", 128'(mem_rready_o), 128'(1'b0));
        next_cycle();
        flush_i = 1'b0;
        settle();
        check("post_flush_push", 128'(push_o), 128'(1'b0));
        check("post_flush_ready", 128'(meta_ready_o), 128'(1'b1));
        check("post_flush_data", 128'(data_o), 128'(beat(4'd0, 64'h66, 2'b00, 1'b0, 1'b0)));
`ifdef AXI_TO_MEM_R_STATS_EN
        check("flush_stat_beats", 128'(stat_beats_o), 128'(32'd12));
        check("flush_stat_bursts", 128'(stat_bursts_o), 128'(32'd5));
`endif
        mem_rvalid_i = 1'b0;

        // Maximum length burst: 256 beats, last only on the final one
        load_meta(4'hC, 8'd255, 1'b1);
        mem_rvalid_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem_rdata_i = 64'(i) << 8;
            settle();
            check("len255_data", 128'(data_o), 128'(beat(4'hC, 64'(i) << 8, 2'b00, i == 255, 1'b1)));
            next_cycle();
        end
        mem_rvalid_i = 1'b0;
        settle();
        check("len255_done_ready", 128'(meta_ready_o), 128'(1'b1));
`ifdef AXI_TO_MEM_R_STATS_EN
        check("stat_beats", 128'(stat_beats_o), 128'(32'd268));
        check("stat_bursts", 128'(stat_bursts_o), 128'(32'd6));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
